// File: rtl/pipeline_pkg.sv
// Shared definitions for the memory-access stage and its neighbours:
// FSM state type, access-size encodings and write-back mux selects.
package pipeline_pkg;

    // Memory-access handshake states.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2
    } mem_state_t;

    // Load/store funct3 encodings (stores reuse the low two bits as size).
    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;

    // Access size as carried in funct3[1:0].
    localparam logic [1:0] SZ_B = 2'b00;
    localparam logic [1:0] SZ_H = 2'b01;
    localparam logic [1:0] SZ_W = 2'b10;

    // Write-back result mux selects.
    localparam logic [2:0] RS_ALU  = 3'b000;
    localparam logic [2:0] RS_MEM  = 3'b001;
    localparam logic [2:0] RS_PC4  = 3'b010;
    localparam logic [2:0] RS_CREG = 3'b011;
    localparam logic [2:0] RS_IMM  = 3'b100;

    // Halfwords need an even address, words a multiple of four; bytes never fault.
    function automatic logic is_misaligned(input logic [2:0] funct3,
                                           input logic [1:0] addr_lo);
        case (funct3[1:0])
            SZ_H:    return addr_lo[0];
            SZ_W:    return (addr_lo != 2'b00);
            default: return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/load_align.sv
// Load data alignment: picks the addressed byte/halfword lane out of the
// returned word and sign- or zero-extends it according to funct3.
module load_align
    import pipeline_pkg::*;
(
    input  logic [31:0] rdata,
    input  logic [1:0]  addr,
    input  logic [2:0]  funct3,
    output logic [31:0] read_data
);

    logic [7:0]  byte_lanes [4];
    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_lane
            assign byte_lanes[gi] = rdata[gi*8 +: 8];
        end
    endgenerate

    // Lane select followed by extension; unknown funct3 passes the word through.
    always_comb begin
        byte_sel = byte_lanes[addr];
        half_sel = addr[1] ? rdata[31:16] : rdata[15:0];
        case (funct3)
            F3_LB:   read_data = {{24{byte_sel[7]}}, byte_sel};
            F3_LBU:  read_data = {24'h0, byte_sel};
            F3_LH:   read_data = {{16{half_sel[15]}}, half_sel};
            F3_LHU:  read_data = {16'h0, half_sel};
            F3_LW:   read_data = rdata;
            default: read_data = rdata;
        endcase
    end

endmodule

// File: rtl/mem_access.sv
// Memory-access pipeline stage: issues loads/stores over a req/ready +
// rvalid handshake, stalls upstream while an access is in flight, aligns
// load data and holds the M/W pipeline register consumed by write-back.
// The bus is driven straight from the execute-stage inputs because
// upstream keeps them stable for as long as stall_m is high.
module mem_access
    import pipeline_pkg::*;
#(
    parameter int ADDR_W = 32
) (
    input  logic              clk,
    input  logic              rst,

    input  logic              valid_e,
    input  logic              reg_write_e,
    input  logic              mem_read_e,
    input  logic              mem_write_e,
    input  logic [2:0]        result_src_e,
    input  logic [2:0]        funct3_e,
    input  logic [31:0]       alu_result_e,
    input  logic [31:0]       write_data_e,
    input  logic [31:0]       pc_plus4_e,
    input  logic [31:0]       imm_ext_e,
    input  logic [31:0]       c_reg_data_out_e,
    input  logic [4:0]        rd_e,

    output logic              dmem_req,
    output logic              dmem_we,
    output logic [ADDR_W-1:0] dmem_addr,
    output logic [31:0]       dmem_wdata,
    output logic [3:0]        dmem_wstrb,
    input  logic              dmem_ready,
    input  logic              dmem_rvalid,
    input  logic [31:0]       dmem_rdata,

    output logic              stall_m,
    output logic              misalign_m,

    output logic              valid_m,
    output logic              reg_write_m,
    output logic [2:0]        result_src_m,
    output logic [4:0]        rd_m,
    output logic [31:0]       alu_result_m,
    output logic [31:0]       read_data_m,
    output logic [31:0]       pc_plus4_m,
    output logic [31:0]       imm_ext_m,
    output logic [31:0]       c_reg_data_out_m
);

    mem_state_t state_q, state_d;

    logic mem_op;
    logic misaligned;
    logic aligned_op;
    logic done;

    logic [31:0] read_data_d;

    logic        valid_q;
    logic        reg_write_q;
    logic        misalign_q;
    logic [2:0]  result_src_q;
    logic [4:0]  rd_q;
    logic [31:0] alu_result_q;
    logic [31:0] read_data_q;
    logic [31:0] pc_plus4_q;
    logic [31:0] imm_ext_q;
    logic [31:0] c_reg_data_out_q;

    // Classify the incoming execute-stage instruction.
    always_comb begin
        mem_op     = valid_e && (mem_read_e || mem_write_e);
        misaligned = mem_op && is_misaligned(funct3_e, alu_result_e[1:0]);
        aligned_op = mem_op && !misaligned;
    end

    // Handshake state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state, bus request and stall. A store finishes on acceptance; a
    // load needs rvalid, which is only looked at once in WAIT.
    always_comb begin
        state_d  = state_q;
        dmem_req = 1'b0;
        done     = 1'b0;
        stall_m  = 1'b0;
        case (state_q)
            IDLE: begin
                if (aligned_op) begin
                    state_d = REQ;
                    stall_m = 1'b1;
                end
            end
            REQ: begin
                dmem_req = 1'b1;
                if (dmem_ready) begin
                    if (mem_write_e) begin
                        done    = 1'b1;
                        state_d = IDLE;
                    end else begin
                        state_d = WAIT;
                    end
                end
                stall_m = !done;
            end
            WAIT: begin
                if (dmem_rvalid) begin
                    done    = 1'b1;
                    state_d = IDLE;
                end
                stall_m = !done;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Bus address/direction straight from the held execute-stage inputs.
    always_comb begin
        dmem_we   = mem_write_e;
        dmem_addr = {alu_result_e[ADDR_W-1:2], 2'b00};
    end

    // Store data is replicated into every lane so the strobe alone picks the bytes.
    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_wlane
            assign dmem_wdata[gi*8 +: 8] =
                (funct3_e[1:0] == SZ_B) ? write_data_e[7:0] :
                (funct3_e[1:0] == SZ_H) ? write_data_e[(gi % 2)*8 +: 8] :
                                          write_data_e[gi*8 +: 8];
        end
    endgenerate

    // Byte enables positioned at the addressed lane.
    always_comb begin
        case (funct3_e[1:0])
            SZ_B:    dmem_wstrb = 4'b0001 << alu_result_e[1:0];
            SZ_H:    dmem_wstrb = 4'b0011 << alu_result_e[1:0];
            default: dmem_wstrb = 4'b1111;
        endcase
    end

    load_align u_load_align (
        .rdata     (dmem_rdata),
        .addr      (alu_result_e[1:0]),
        .funct3    (funct3_e),
        .read_data (read_data_d)
    );

    // M/W register: capture on commit, insert a bubble while stalled.
    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q          <= 1'b0;
            reg_write_q      <= 1'b0;
            misalign_q       <= 1'b0;
            result_src_q     <= '0;
            rd_q             <= '0;
            alu_result_q     <= '0;
            read_data_q      <= '0;
            pc_plus4_q       <= '0;
            imm_ext_q        <= '0;
            c_reg_data_out_q <= '0;
        end else if (stall_m) begin
            valid_q     <= 1'b0;
            reg_write_q <= 1'b0;
            misalign_q  <= 1'b0;
        end else begin
            valid_q          <= valid_e;
            reg_write_q      <= valid_e && reg_write_e && !misaligned;
            misalign_q       <= misaligned;
            result_src_q     <= result_src_e;
            rd_q             <= rd_e;
            alu_result_q     <= alu_result_e;
            read_data_q      <= read_data_d;
            pc_plus4_q       <= pc_plus4_e;
            imm_ext_q        <= imm_ext_e;
            c_reg_data_out_q <= c_reg_data_out_e;
        end
    end

    assign valid_m          = valid_q;
    assign reg_write_m      = reg_write_q;
    assign misalign_m       = misalign_q;
    assign result_src_m     = result_src_q;
    assign rd_m             = rd_q;
    assign alu_result_m     = alu_result_q;
    assign read_data_m      = read_data_q;
    assign pc_plus4_m       = pc_plus4_q;
    assign imm_ext_m        = imm_ext_q;
    assign c_reg_data_out_m = c_reg_data_out_q;

endmodule

// File: tb/tb_mem_access.sv
// Randomised bench for mem_access: the bench plays the upstream stage and
// the data memory, and predicts every committed M/W value, bus transaction
// and stall length from the access rules using plain arithmetic.
module tb_mem_access;

    localparam int BUDGET = 60;

    logic        clk = 1'b0;
    logic        rst;
    logic        valid_e, reg_write_e, mem_read_e, mem_write_e;
    logic [2:0]  result_src_e, funct3_e;
    logic [31:0] alu_result_e, write_data_e, pc_plus4_e, imm_ext_e, c_reg_data_out_e;
    logic [4:0]  rd_e;
    logic        dmem_req, dmem_we;
    logic [31:0] dmem_addr, dmem_wdata;
    logic [3:0]  dmem_wstrb;
    logic        dmem_ready, dmem_rvalid;
    logic [31:0] dmem_rdata;
    logic        stall_m, misalign_m;
    logic        valid_m, reg_write_m;
    logic [2:0]  result_src_m;
    logic [4:0]  rd_m;
    logic [31:0] alu_result_m, read_data_m, pc_plus4_m, imm_ext_m, c_reg_data_out_m;

    int n_checks = 0;
    int n_pass   = 0;
    int n_ops    = 0;

    logic [31:0] mem [16];

    typedef struct packed {
        logic        valid, mem_read, mem_write, rw;
        logic [2:0]  f3, rsrc;
        logic [4:0]  rd;
        logic [31:0] addr, wdata, pc4, imm, creg;
    } op_t;

    mem_access #(.ADDR_W(32)) dut (
        .clk(clk), .rst(rst),
        .valid_e(valid_e), .reg_write_e(reg_write_e), .mem_read_e(mem_read_e),
        .mem_write_e(mem_write_e), .result_src_e(result_src_e), .funct3_e(funct3_e),
        .alu_result_e(alu_result_e), .write_data_e(write_data_e), .pc_plus4_e(pc_plus4_e),
        .imm_ext_e(imm_ext_e), .c_reg_data_out_e(c_reg_data_out_e), .rd_e(rd_e),
        .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
        .dmem_wdata(dmem_wdata), .dmem_wstrb(dmem_wstrb), .dmem_ready(dmem_ready),
        .dmem_rvalid(dmem_rvalid), .dmem_rdata(dmem_rdata),
        .stall_m(stall_m), .misalign_m(misalign_m),
        .valid_m(valid_m), .reg_write_m(reg_write_m), .result_src_m(result_src_m),
        .rd_m(rd_m), .alu_result_m(alu_result_m), .read_data_m(read_data_m),
        .pc_plus4_m(pc_plus4_m), .imm_ext_m(imm_ext_m), .c_reg_data_out_m(c_reg_data_out_m)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    // Expected load result: shift the addressed lane down, then extend.
    function automatic logic [31:0] model_load(input logic [31:0] word, input logic [31:0] a,
                                               input logic [2:0] f3);
        logic [31:0] v;
        v = word >> (8 * (a % 4));
        case (f3)
            3'b000:  begin v = v % 256;   if (v >= 128)   v = v - 256;   end
            3'b100:  v = v % 256;
            3'b001:  begin v = v % 65536; if (v >= 32768) v = v - 65536; end
            3'b101:  v = v % 65536;
            default: v = word;
        endcase
        return v;
    endfunction

    function automatic op_t make_op(input logic valid, input logic rd_en, input logic wr_en,
                                    input logic [2:0] f3, input logic [31:0] addr,
                                    input logic [31:0] wdata);
        op_t o;
        o.valid = valid;  o.mem_read = rd_en;  o.mem_write = wr_en;
        o.rw    = rd_en ? 1'b1 : (wr_en ? 1'b0 : 1'(($urandom % 4) != 0));
        o.f3    = f3;     o.addr = addr;       o.wdata = wdata;
        o.rsrc  = 3'($urandom_range(0, 4));
        o.rd    = 5'($urandom);
        o.pc4   = $urandom; o.imm = $urandom; o.creg = $urandom;
        return o;
    endfunction

    task automatic drive_op(input op_t o);
        valid_e = o.valid;  mem_read_e = o.mem_read;  mem_write_e = o.mem_write;
        reg_write_e = o.rw; funct3_e = o.f3;          result_src_e = o.rsrc;
        rd_e = o.rd;        alu_result_e = o.addr;    write_data_e = o.wdata;
        pc_plus4_e = o.pc4; imm_ext_e = o.imm;        c_reg_data_out_e = o.creg;
    endtask

    task automatic clear_inputs();
        valid_e = 0; mem_read_e = 0; mem_write_e = 0; reg_write_e = 0;
        funct3_e = 0; result_src_e = 0; rd_e = 0; alu_result_e = 0;
        write_data_e = 0; pc_plus4_e = 0; imm_ext_e = 0; c_reg_data_out_e = 0;
    endtask

    // Issue one instruction (called at a negedge) and act as memory until it commits.
    task automatic run_op(input op_t o, input int rdly, input int vdly, output int stalls);
        logic        is_mem, mis, accepted, acc_now, done, bus_ok, bubble_ok;
        int          size, idx, reqs, waits, cyc, exp_stalls;
        logic [31:0] exp_rd, exp_wdata;
        logic [3:0]  exp_strb;

        is_mem = o.valid && (o.mem_read || o.mem_write);
        size   = 1 << o.f3[1:0];
        mis    = is_mem && ((o.addr % size) != 0);
        idx    = int'((o.addr >> 2) % 16);
        exp_rd = model_load(mem[idx], o.addr, o.f3);
        case (o.f3[1:0])
            2'b00:   begin exp_strb = 4'(1 << (o.addr % 4)); exp_wdata = (o.wdata % 256) * 32'h01010101; end
            2'b01:   begin exp_strb = 4'(3 << (o.addr % 4)); exp_wdata = (o.wdata % 65536) * 32'h00010001; end
            default: begin exp_strb = 4'hF; exp_wdata = o.wdata; end
        endcase
        if (!is_mem || mis)  exp_stalls = 0;
        else if (o.mem_write) exp_stalls = 1 + rdly;
        else                  exp_stalls = 2 + rdly + vdly;

        drive_op(o);
        stalls = 0; reqs = 0; waits = 0; cyc = 0;
        accepted = 0; done = 0; bus_ok = 1; bubble_ok = 1;
        while (!done && cyc < BUDGET) begin
            if (cyc > 0 && (valid_m || reg_write_m)) bubble_ok = 0;
            acc_now = 0;
            dmem_ready = 0; dmem_rvalid = 0; dmem_rdata = $urandom;
            if (dmem_req) begin
                if (dmem_we !== o.mem_write || dmem_addr !== (o.addr & 32'hFFFF_FFFC)) bus_ok = 0;
                if (o.mem_write && (dmem_wstrb !== exp_strb || dmem_wdata !== exp_wdata)) bus_ok = 0;
                if (reqs == rdly) begin dmem_ready = 1; acc_now = 1; end
                reqs++;
            end else if (accepted) begin
                if (waits == vdly) begin dmem_rvalid = 1; dmem_rdata = mem[idx]; end
                waits++;
            end
            #1;
            if (stall_m) stalls++;
            else done = 1;
            if (acc_now) begin
                accepted = 1;
                if (dmem_we)
                    for (int b = 0; b < 4; b++)
                        if (dmem_wstrb[b]) mem[idx][b*8 +: 8] = dmem_wdata[b*8 +: 8];
            end
            @(negedge clk);
            cyc++;
        end
        dmem_ready = 0; dmem_rvalid = 0;

        if (!done) begin
            check_eq("timeout", 32'(cyc), 32'(BUDGET + 1));
            rst = 1; clear_inputs(); @(negedge clk); rst = 0;
            return;
        end
        check_eq("valid_m",        32'(valid_m),     32'(o.valid));
        check_eq("reg_write_m",    32'(reg_write_m), 32'(o.valid && o.rw && !mis));
        check_eq("misalign_m",     32'(misalign_m),  32'(mis));
        check_eq("alu_result_m",   alu_result_m,     o.addr);
        check_eq("rd_m",           32'(rd_m),        32'(o.rd));
        check_eq("result_src_m",   32'(result_src_m), 32'(o.rsrc));
        check_eq("pc_plus4_m",     pc_plus4_m,       o.pc4);
        check_eq("imm_ext_m",      imm_ext_m,        o.imm);
        check_eq("c_reg_data_m",   c_reg_data_out_m, o.creg);
        check_eq("stall_cycles",   32'(stalls),      32'(exp_stalls));
        check_eq("req_cycles",     32'(reqs),        (is_mem && !mis) ? 32'(rdly + 1) : 32'd0);
        if (is_mem && !mis && o.mem_read && !o.mem_write) check_eq("read_data_m", read_data_m, exp_rd);
        if (reqs > 0)   check_eq("bus_stable", 32'(bus_ok), 32'd1);
        if (stalls > 0) check_eq("bubbles",    32'(bubble_ok), 32'd1);
        $display("op %0d: v=%0d rd=%0d wr=%0d f3=%0d addr=%h rdly=%0d vdly=%0d mis=%0d stalls=%0d",
                 n_ops, o.valid, o.mem_read, o.mem_write, o.f3, o.addr, rdly, vdly, mis, stalls);
        n_ops++;
    endtask

    initial begin
        op_t         o;
        int          st, r;
        logic [2:0]  f3;
        logic [31:0] a;
        logic [2:0]  ld_f3 [5];
        ld_f3[0] = 3'b000; ld_f3[1] = 3'b001; ld_f3[2] = 3'b010; ld_f3[3] = 3'b100; ld_f3[4] = 3'b101;

        for (int i = 0; i < 16; i++) mem[i] = $urandom;
        rst = 1; clear_inputs();
        dmem_ready = 0; dmem_rvalid = 0; dmem_rdata = 0;
        repeat (2) @(negedge clk);
        rst = 0;
        #1;
        check_eq("rst_valid_m",   32'(valid_m),     32'd0);
        check_eq("rst_reg_write", 32'(reg_write_m), 32'd0);
        check_eq("rst_alu_m",     alu_result_m,     32'd0);
        check_eq("rst_read_data", read_data_m,      32'd0);
        check_eq("rst_rd_m",      32'(rd_m),        32'd0);
        check_eq("rst_dmem_req",  32'(dmem_req),    32'd0);
        check_eq("rst_misalign",  32'(misalign_m),  32'd0);
        check_eq("rst_stall",     32'(stall_m),     32'd0);
        @(negedge clk);

        // ALU op commits next cycle with no bus activity.
        o = make_op(1, 0, 0, 3'b000, 32'h1234, 0); o.rd = 5; o.rw = 1;
        run_op(o, 0, 0, st);
        check_eq("alu_rd5", 32'(rd_m), 32'd5);

        // lb/lhu against a known word.
        mem[(32'h100 >> 2) % 16] = 32'h80FF_0000;
        run_op(make_op(1, 1, 0, 3'b000, 32'h103, 0), 0, 0, st);
        check_eq("lb_0x103",  read_data_m, 32'hFFFF_FF80);
        check_eq("lb_stall2", 32'(st),     32'd2);
        run_op(make_op(1, 1, 0, 3'b101, 32'h102, 0), 0, 0, st);
        check_eq("lhu_0x102", read_data_m, 32'h0000_80FF);

        // sb with ready held off for three request cycles.
        run_op(make_op(1, 0, 1, 3'b000, 32'h101, 32'h0000_00AB), 3, 0, st);
        check_eq("sb_stall4", 32'(st), 32'd4);
        check_eq("sb_mem",    32'(mem[(32'h100 >> 2) % 16][15:8]), 32'hAB);

        // Misaligned word load.
        run_op(make_op(1, 1, 0, 3'b010, 32'h102, 0), 0, 0, st);
        check_eq("lw_mis_pulse", 32'(misalign_m), 32'd1);

        // Reset while waiting for load data; a late rvalid must be ignored.
        drive_op(make_op(1, 1, 0, 3'b010, 32'h104, 0));
        @(negedge clk); dmem_ready = 1;
        @(negedge clk); dmem_ready = 0; #1;
        check_eq("wait_stall", 32'(stall_m), 32'd1);
        rst = 1; clear_inputs();
        @(negedge clk); rst = 0; #1;
        check_eq("rstw_stall",  32'(stall_m),  32'd0);
        check_eq("rstw_req",    32'(dmem_req), 32'd0);
        check_eq("rstw_valid",  32'(valid_m),  32'd0);
        check_eq("rstw_alu",    alu_result_m,  32'd0);
        dmem_rvalid = 1; dmem_rdata = 32'hDEAD_BEEF;
        @(negedge clk); dmem_rvalid = 0; #1;
        check_eq("late_rv_stall", 32'(stall_m),  32'd0);
        check_eq("late_rv_req",   32'(dmem_req), 32'd0);
        check_eq("late_rv_valid", 32'(valid_m),  32'd0);
        @(negedge clk);

        // Random back-to-back traffic.
        for (int n = 0; n < 150; n++) begin
            r = $urandom_range(0, 9);
            a = 32'h100 + $urandom_range(0, 63);
            if (r <= 1) begin
                o = make_op(1, 0, 0, 3'($urandom), $urandom, $urandom);
            end else if (r <= 5) begin
                f3 = ld_f3[$urandom_range(0, 4)];
                if ($urandom_range(0, 1) == 1) a = a & ~((32'd1 << f3[1:0]) - 32'd1);
                o = make_op(1, 1, 0, f3, a, $urandom);
            end else if (r <= 8) begin
                f3 = 3'($urandom_range(0, 2));
                if ($urandom_range(0, 1) == 1) a = a & ~((32'd1 << f3[1:0]) - 32'd1);
                o = make_op(1, 0, 1, f3, a, $urandom);
            end else begin
                o = make_op(0, 1, 0, 3'b010, a, $urandom);
            end
            run_op(o, $urandom_range(0, 3), $urandom_range(0, 3), st);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
